// File: rtl/mem_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_if : execute/memory/writeback handshake bundle           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mem_stage_if #(
   parameter int EX_BUS_W = 93,
   parameter int WB_BUS_W = 88
);
   logic                ex_to_mem_valid;
   logic                mem_allowin;
   logic [EX_BUS_W-1:0] ex_to_mem_bus;
   logic                ex_req_outstanding;
   logic                data_sram_data_ok;
   logic [31:0]         data_sram_rdata;
   logic                wb_allowin;
   logic                mem_to_wb_valid;
   logic [WB_BUS_W-1:0] mem_to_wb_bus;
   logic [38:0]         mem_to_id_bus;
   logic [1:0]          mem_to_ex_bus;

   // master = surrounding pipeline; slave = the memory stage itself
   modport master (
      output ex_to_mem_valid, ex_to_mem_bus, ex_req_outstanding,
             data_sram_data_ok, data_sram_rdata, wb_allowin,
      input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
             mem_to_id_bus, mem_to_ex_bus
   );
   modport slave (
      input  ex_to_mem_valid, ex_to_mem_bus, ex_req_outstanding,
             data_sram_data_ok, data_sram_rdata, wb_allowin,
      output mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
             mem_to_id_bus, mem_to_ex_bus
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage : memory-access pipeline stage with response buffering   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_stage #(
   parameter int EX_BUS_W = 93,
   parameter int WB_BUS_W = 88
) (
   input  wire         clk,
   input  wire         reset,
   input  wire         flush,
   mem_stage_if.slave  bus
);
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic [4:0]  rf_waddr;
      logic        rf_we;
      logic        res_from_mem;
      logic        ld_b;
      logic        ld_h;
      logic        ld_u;
      logic        req_sent;
      logic        csr_re;
      logic        ertn;
      logic        excep_en;
      logic [5:0]  ecode;
      logic [8:0]  esubcode;
   } ex_bus_t;

   logic                mem_valid_q, mem_valid_d;
   ex_bus_t             ex_q, ex_d;
   logic                data_buf_valid_q, data_buf_valid_d;
   logic [31:0]         data_buf_q, data_buf_d;
   logic [1:0]          discard_cnt_q, discard_cnt_d;

   logic [EX_BUS_W-1:0] ex_raw;
   logic [WB_BUS_W-1:0] wb_bus;
   logic                need_data, resp_hit, mem_ready_go, mem_allowin;
   logic                wb_valid, leaving, discard_dec, mem_out;
   logic [2:0]          cnt_sum;
   logic [31:0]         ld_word, load_value, final_result;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic                rf_we_vis, blocking;

   assign ex_raw       = bus.ex_to_mem_bus;
   assign need_data    = ex_q.req_sent & ~ex_q.excep_en;
   assign resp_hit     = bus.data_sram_data_ok & (discard_cnt_q == 2'd0);
   assign mem_ready_go = ~need_data | data_buf_valid_q | resp_hit;
   assign mem_allowin  = ~mem_valid_q | (mem_ready_go & bus.wb_allowin);
   assign wb_valid     = mem_valid_q & mem_ready_go & ~flush;
   assign leaving      = wb_valid & bus.wb_allowin;
   assign discard_dec  = bus.data_sram_data_ok & (discard_cnt_q != 2'd0);
   // a request the flushed instruction issued but never saw answered
   assign mem_out      = mem_valid_q & need_data & ~data_buf_valid_q & ~resp_hit;

   always_comb begin
      mem_valid_d      = mem_valid_q;
      ex_d             = ex_q;
      data_buf_valid_d = data_buf_valid_q;
      data_buf_d       = data_buf_q;
      discard_cnt_d    = discard_cnt_q;
      cnt_sum          = 3'd0;

      if (flush)
         mem_valid_d = 1'b0;
      else if (mem_allowin)
         mem_valid_d = bus.ex_to_mem_valid;

      if (bus.ex_to_mem_valid & mem_allowin)
         ex_d = ex_bus_t'(ex_raw);

      if (flush | leaving)
         data_buf_valid_d = 1'b0;
      else if (resp_hit & mem_valid_q & need_data & ~bus.wb_allowin) begin
         data_buf_valid_d = 1'b1;
         data_buf_d       = bus.data_sram_rdata;
      end

      if (flush) begin
         cnt_sum = {1'b0, discard_cnt_q} - {2'b00, discard_dec}
                 + {2'b00, mem_out} + {2'b00, bus.ex_req_outstanding};
         discard_cnt_d = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];
      end else if (discard_dec) begin
         discard_cnt_d = discard_cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_valid_q      <= 1'b0;
         ex_q             <= '0;
         data_buf_valid_q <= 1'b0;
         data_buf_q       <= 32'd0;
         discard_cnt_q    <= 2'd0;
      end else begin
         mem_valid_q      <= mem_valid_d;
         ex_q             <= ex_d;
         data_buf_valid_q <= data_buf_valid_d;
         data_buf_q       <= data_buf_d;
         discard_cnt_q    <= discard_cnt_d;
      end
   end

   // load extraction: buffered data wins over the live response
   always_comb begin
      ld_word = data_buf_valid_q ? data_buf_q : bus.data_sram_rdata;
      case (ex_q.alu_result[1:0])
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = ex_q.alu_result[1] ? ld_word[31:16] : ld_word[15:0];
      if (ex_q.ld_b)
         load_value = {{24{ld_byte[7] & ~ex_q.ld_u}}, ld_byte};
      else if (ex_q.ld_h)
         load_value = {{16{ld_half[15] & ~ex_q.ld_u}}, ld_half};
      else
         load_value = ld_word;
      final_result = ex_q.res_from_mem ? load_value : ex_q.alu_result;
   end

   assign rf_we_vis = ex_q.rf_we & mem_valid_q;
   assign blocking  = mem_valid_q & ((ex_q.res_from_mem & ~mem_ready_go) | ex_q.csr_re);
   assign wb_bus    = {ex_q.pc, rf_we_vis, ex_q.rf_waddr, final_result, ex_q.csr_re,
                       ex_q.ertn, ex_q.excep_en, ex_q.ecode, ex_q.esubcode};

   assign bus.mem_allowin     = mem_allowin;
   assign bus.mem_to_wb_valid = wb_valid;
   assign bus.mem_to_wb_bus   = wb_bus;
   assign bus.mem_to_id_bus   = {blocking, rf_we_vis, ex_q.rf_waddr, final_result};
   assign bus.mem_to_ex_bus   = {mem_valid_q & ex_q.excep_en, mem_valid_q & ex_q.ertn};
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_stage : directed self-checking bench for mem_stage          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_stage;
   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   n_vec = 0;
   int   n_err = 0;

   mem_stage_if #(.EX_BUS_W(93), .WB_BUS_W(88)) mif ();

   mem_stage #(.EX_BUS_W(93), .WB_BUS_W(88)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (mif.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish (got timeout, want finish)");
      $fatal(1);
   end

   function automatic logic [92:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                      input logic [4:0] wa, input logic we, input logic rfm,
                                      input logic ldb, input logic ldh, input logic ldu,
                                      input logic req, input logic csr, input logic er,
                                      input logic exc, input logic [5:0] ec, input logic [8:0] es);
      return {pc, alu, wa, we, rfm, ldb, ldh, ldu, req, csr, er, exc, ec, es};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      mif.ex_to_mem_valid    = 1'b0;
      mif.ex_to_mem_bus      = '0;
      mif.ex_req_outstanding = 1'b0;
      mif.data_sram_data_ok  = 1'b0;
      mif.data_sram_rdata    = 32'h0;
      mif.wb_allowin         = 1'b1;
      #2;
      n_vec++;
      if (mif.mem_to_wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %b want 0", mif.mem_to_wb_valid); end
      step(); step();
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_ex_bus !== 2'b00) begin n_err++; $display("FAIL reset_ex_bus got %b want 00", mif.mem_to_ex_bus); end
      n_vec++;
      if (mif.mem_to_id_bus !== 39'h0) begin n_err++; $display("FAIL reset_id_bus got %h want 0", mif.mem_to_id_bus); end
      n_vec++;
      if (mif.mem_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin got %b want 1", mif.mem_allowin); end
      step();
      reset = 1'b0;
   endtask

   task automatic test_load_word();
      mif.ex_to_mem_valid = 1'b1;
      mif.ex_to_mem_bus   = mk(32'h1c000010, 32'h100, 5'd5, 1, 1, 0, 0, 0, 1, 0, 0, 0, 6'd0, 9'd0);
      step();
      mif.ex_to_mem_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_wb_valid !== 1'b0 || mif.mem_allowin !== 1'b0) begin
         n_err++; $display("FAIL lw_wait got valid=%b allowin=%b want 0 0", mif.mem_to_wb_valid, mif.mem_allowin);
      end
      n_vec++;
      if (mif.mem_to_id_bus[38] !== 1'b1) begin n_err++; $display("FAIL lw_blocking got %b want 1", mif.mem_to_id_bus[38]); end
      step();
      mif.data_sram_data_ok = 1'b1;
      mif.data_sram_rdata   = 32'hDEADBEEF;
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_to_wb_bus[49:18] !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL lw_done got valid=%b res=%h want 1 deadbeef", mif.mem_to_wb_valid, mif.mem_to_wb_bus[49:18]);
      end
      n_vec++;
      if (mif.mem_to_id_bus !== {1'b0, 1'b1, 5'd5, 32'hDEADBEEF}) begin
         n_err++; $display("FAIL lw_forward got %h want %h", mif.mem_to_id_bus, {1'b0, 1'b1, 5'd5, 32'hDEADBEEF});
      end
      n_vec++;
      if (mif.mem_to_wb_bus[87:56] !== 32'h1c000010) begin n_err++; $display("FAIL lw_pc got %h want 1c000010", mif.mem_to_wb_bus[87:56]); end
      step();
      mif.data_sram_data_ok = 1'b0;
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_wb_valid !== 1'b0) begin n_err++; $display("FAIL lw_left got %b want 0", mif.mem_to_wb_valid); end
      step();
   endtask

   task automatic test_load_ext();
      logic [31:0] alu [6] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100, 32'h102};
      logic        ldb [6] = '{1, 1, 0, 1, 0, 0};
      logic        ldh [6] = '{0, 0, 1, 0, 1, 1};
      logic        ldu [6] = '{0, 0, 1, 0, 0, 0};
      logic [31:0] exp [6] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080F1,
                               32'hFFFFFF82, 32'h00007F82, 32'hFFFF80F1};
      for (int i = 0; i < 6; i++) begin
         mif.ex_to_mem_valid = 1'b1;
         mif.ex_to_mem_bus   = mk(32'h1c000100, alu[i], 5'd7, 1, 1, ldb[i], ldh[i], ldu[i], 1, 0, 0, 0, 6'd0, 9'd0);
         step();
         mif.ex_to_mem_valid   = 1'b0;
         mif.data_sram_data_ok = 1'b1;
         mif.data_sram_rdata   = 32'h80F17F82;
         @(negedge clk);
         n_vec++;
         if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_to_wb_bus[49:18] !== exp[i]) begin
            n_err++; $display("FAIL ld_ext[%0d] got valid=%b res=%h want 1 %h", i, mif.mem_to_wb_valid, mif.mem_to_wb_bus[49:18], exp[i]);
         end
         step();
         mif.data_sram_data_ok = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      mif.ex_to_mem_valid = 1'b1;
      mif.ex_to_mem_bus   = mk(32'h1c000200, 32'h200, 5'd9, 1, 1, 0, 0, 0, 1, 0, 0, 0, 6'd0, 9'd0);
      step();
      mif.ex_to_mem_valid   = 1'b0;
      mif.wb_allowin        = 1'b0;
      mif.data_sram_data_ok = 1'b1;
      mif.data_sram_rdata   = 32'h12345678;
      step();
      mif.data_sram_data_ok = 1'b0;
      mif.data_sram_rdata   = 32'hFFFFFFFF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_vec++;
         if (mif.mem_allowin !== 1'b0 || mif.mem_to_wb_bus[49:18] !== 32'h12345678) begin
            n_err++; $display("FAIL bp_hold[%0d] got allowin=%b res=%h want 0 12345678", i, mif.mem_allowin, mif.mem_to_wb_bus[49:18]);
         end
         step();
      end
      mif.wb_allowin = 1'b1;
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_allowin !== 1'b1 || mif.mem_to_wb_bus[49:18] !== 32'h12345678) begin
         n_err++; $display("FAIL bp_release got valid=%b allowin=%b res=%h want 1 1 12345678",
                           mif.mem_to_wb_valid, mif.mem_allowin, mif.mem_to_wb_bus[49:18]);
      end
      step();
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_wb_valid !== 1'b0) begin n_err++; $display("FAIL bp_once got %b want 0", mif.mem_to_wb_valid); end
      step();
   endtask

   task automatic test_flush();
      mif.ex_to_mem_valid = 1'b1;
      mif.ex_to_mem_bus   = mk(32'h1c000300, 32'h300, 5'd3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 6'd0, 9'd0);
      step();
      mif.ex_to_mem_valid    = 1'b0;
      mif.ex_req_outstanding = 1'b1;
      flush                  = 1'b1;
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_wb_valid !== 1'b0) begin n_err++; $display("FAIL fl_mask got %b want 0", mif.mem_to_wb_valid); end
      step();
      flush                  = 1'b0;
      mif.ex_req_outstanding = 1'b0;
      mif.ex_to_mem_valid    = 1'b1;
      mif.ex_to_mem_bus      = mk(32'h1c000304, 32'h304, 5'd4, 1, 1, 0, 0, 0, 1, 0, 0, 0, 6'd0, 9'd0);
      mif.data_sram_data_ok  = 1'b1;
      mif.data_sram_rdata    = 32'hAAAA0001;
      step();
      mif.ex_to_mem_valid = 1'b0;
      mif.data_sram_rdata = 32'hAAAA0002;
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_wb_valid !== 1'b0 || mif.mem_allowin !== 1'b0) begin
         n_err++; $display("FAIL fl_discard2 got valid=%b allowin=%b want 0 0", mif.mem_to_wb_valid, mif.mem_allowin);
      end
      step();
      mif.data_sram_rdata = 32'h55667788;
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_to_wb_bus[49:18] !== 32'h55667788) begin
         n_err++; $display("FAIL fl_third got valid=%b res=%h want 1 55667788", mif.mem_to_wb_valid, mif.mem_to_wb_bus[49:18]);
      end
      step();
      mif.data_sram_data_ok = 1'b0;
      // flush coinciding with a new arrival drops it
      mif.ex_to_mem_valid = 1'b1;
      mif.ex_to_mem_bus   = mk(32'h1c000308, 32'h55, 5'd6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 9'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      mif.ex_to_mem_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_wb_valid !== 1'b0 || mif.mem_to_id_bus[37] !== 1'b0) begin
         n_err++; $display("FAIL fl_drop got valid=%b we=%b want 0 0", mif.mem_to_wb_valid, mif.mem_to_id_bus[37]);
      end
      step();
   endtask

   task automatic test_exception();
      mif.ex_to_mem_valid = 1'b1;
      mif.ex_to_mem_bus   = mk(32'h1c000400, 32'h1234, 5'd1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6'h0D, 9'h001);
      step();
      mif.ex_to_mem_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_ex_bus !== 2'b10 || mif.mem_to_wb_valid !== 1'b1) begin
         n_err++; $display("FAIL exc_flags got ex=%b valid=%b want 10 1", mif.mem_to_ex_bus, mif.mem_to_wb_valid);
      end
      n_vec++;
      if (mif.mem_to_wb_bus[17:0] !== {1'b0, 1'b0, 1'b1, 6'h0D, 9'h001}) begin
         n_err++; $display("FAIL exc_fields got %h want %h", mif.mem_to_wb_bus[17:0], {1'b0, 1'b0, 1'b1, 6'h0D, 9'h001});
      end
      step();
      mif.ex_to_mem_valid = 1'b1;
      mif.ex_to_mem_bus   = mk(32'h1c000404, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'd0, 9'd0);
      step();
      mif.ex_to_mem_valid = 1'b1;
      mif.ex_to_mem_bus   = mk(32'h1c000408, 32'h77, 5'd12, 1, 0, 0, 0, 0, 0, 1, 0, 0, 6'd0, 9'd0);
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_ex_bus !== 2'b01) begin n_err++; $display("FAIL ertn_flag got %b want 01", mif.mem_to_ex_bus); end
      step();
      mif.ex_to_mem_valid = 1'b0;
      mif.wb_allowin      = 1'b0;
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_id_bus !== {1'b1, 1'b1, 5'd12, 32'h77}) begin
         n_err++; $display("FAIL csr_block got %h want %h", mif.mem_to_id_bus, {1'b1, 1'b1, 5'd12, 32'h77});
      end
      step();
      mif.wb_allowin = 1'b1;
      step();
      @(negedge clk);
      n_vec++;
      if (mif.mem_to_id_bus[38:37] !== 2'b00 || mif.mem_to_ex_bus !== 2'b00) begin
         n_err++; $display("FAIL idle_mask got id=%b ex=%b want 00 00", mif.mem_to_id_bus[38:37], mif.mem_to_ex_bus);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3] = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
      for (int i = 0; i < 3; i++) begin
         mif.ex_to_mem_valid = 1'b1;
         mif.ex_to_mem_bus   = mk(32'h1c000500 + 32'(i * 4), vals[i], 5'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 9'd0);
         step();
         @(negedge clk);
         n_vec++;
         if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_to_wb_bus[49:18] !== vals[i]) begin
            n_err++; $display("FAIL b2b[%0d] got valid=%b res=%h want 1 %h", i, mif.mem_to_wb_valid, mif.mem_to_wb_bus[49:18], vals[i]);
         end
      end
      step();
      mif.ex_to_mem_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_ext();
      test_backpressure();
      test_flush();
      test_exception();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of writeback.
- Holds one instruction and waits for the data-memory response (data_ok) when execute issued a request.
- Extends load data and forwards results and blocking info back to decode.
- Reports exception/ertn status to execute and discards stale memory responses after a flush.

Parameters:
- EX_BUS_W, 93, width of ex_to_mem_bus
- WB_BUS_W, 88, width of mem_to_wb_bus

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  exception/ertn flush from writeback
- ex_to_mem_valid  in  1  execute has a ready instruction
- mem_allowin  out  1  stage can accept an instruction
- ex_to_mem_bus  in  EX_BUS_W  {pc[31:0], alu_result[31:0], rf_waddr[4:0], rf_we, res_from_mem, ld_b, ld_h, ld_u, req_sent, csr_re, ertn, excep_en, ecode[5:0], esubcode[8:0]} (MSB first)
- ex_req_outstanding  in  1  execute holds an accepted-but-unanswered request
- data_sram_data_ok  in  1  read/write response valid
- data_sram_rdata  in  32  read data
- wb_allowin  in  1  writeback can accept
- mem_to_wb_valid  out  1  instruction leaving to writeback
- mem_to_wb_bus  out  WB_BUS_W  {pc, rf_we, rf_waddr, final_result[31:0], csr_re, ertn, excep_en, ecode, esubcode}
- mem_to_id_bus  out  39  {blocking, rf_we&valid, rf_waddr, final_result}
- mem_to_ex_bus  out  2  {mem_valid&excep_en, mem_valid&ertn}

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - mem_valid=0, all latched bus fields=0, data_buf_valid=0, data_buf=0, discard_cnt=0.
  - Hence mem_to_wb_valid=0, mem_to_ex_bus=0, mem_to_id_bus=0.
- Valid register:
  - flush clears it (priority over load).
  - Otherwise, when mem_allowin, mem_valid <= ex_to_mem_valid.
  - Bus fields latch only when ex_to_mem_valid & mem_allowin.
- Handshake:
  - need_data = req_sent & ~excep_en.
  - resp_hit = data_sram_data_ok & (discard_cnt==0).
  - mem_ready_go = ~need_data | data_buf_valid | resp_hit.
  - mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
  - mem_to_wb_valid = mem_valid & mem_ready_go & ~flush.
- Response buffer:
  - On resp_hit with mem_valid & need_data & ~wb_allowin: data_buf <= rdata, data_buf_valid <= 1.
  - Cleared when the instruction leaves (mem_to_wb_valid & wb_allowin) or on flush.
  - Load data source is data_buf_valid ? data_buf : data_sram_rdata.
- Discard counter (2 bit):
  - On flush: mem_out = mem_valid & need_data & ~data_buf_valid & ~resp_hit; discard_cnt_next = discard_cnt - (data_ok & discard_cnt!=0) + mem_out + ex_req_outstanding.
  - Otherwise each data_ok with discard_cnt!=0 decrements the counter.
  - Max value 2; never underflows.
  - A discarded response never sets data_buf or mem_ready_go.
- Load extension (byte offset = alu_result[1:0]):
  - ld_b selects byte[off]; sign-extends, or zero-extends if ld_u.
  - ld_h selects half[off[1]] with the same sign/zero rule.
  - Otherwise the full word.
  - final_result = res_from_mem ? load_value : alu_result.
- mem_to_id_bus: blocking = mem_valid & ((res_from_mem & ~mem_ready_go) | csr_re).
- Output masking:
  - rf_we is masked by mem_valid in both output buses.
  - Exception fields pass through unchanged.
- Simultaneous flush + incoming valid: the instruction is dropped; mem_valid=0 next cycle.

Test Plan:
- Load word: pc=0x1c000010, alu_result=0x100, req_sent=1; data_ok next cycle, rdata=0xDEADBEEF, wb_allowin=1 -> mem_to_wb_valid=1 that cycle, final_result=0xDEADBEEF.
- Byte/half extension: rdata=0x80F17F82, offset 1:
  - ld_b -> 0x0000007F.
  - offset 3, ld_b -> 0xFFFFFF80.
  - ld_h offset 2 with ld_u -> 0x000080F1.
- Backpressure: data_ok arrives while wb_allowin=0 for 3 cycles -> data buffered, mem_allowin=0; when wb_allowin=1, final_result equals the buffered value and mem_to_wb_valid=1 once.
- Flush mid-wait: MEM outstanding and ex_req_outstanding=1, flush -> discard_cnt=2; next two data_ok are ignored; the third data_ok completes a new load.
- Blocking/forwarding: load waiting -> mem_to_id_bus[38]=1; after data_ok -> 0 and final_result is forwarded.
- Exception passthrough: excep_en=1 with req_sent=0 -> mem_to_ex_bus=2'b10, mem_to_wb_valid=1 without waiting for data_ok.
